// File: rtl/keypad_pin_entry.sv
// keypad_pin_entry: collects decimal keypresses into an 8-bit PIN and submits it with a one-cycle strobe
module keypad_pin_entry #(
  parameter int NUM_DIGITS     = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int GUARD_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [7:0] psswrd_atmpt,
  output logic       try_psswrd,
  output logic       entry_error,
  output logic       timeout,
  output logic [1:0] digit_count,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, SEND, GUARD} state_t;
  state_t state_q, state_d;
  logic [7:0] acc_q, acc_d, pin_q, pin_d;
  logic [9:0] acc_w, acc_nxt;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [GW-1:0] grd_q, grd_d;
  logic [1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, try_q, try_d, err_q, err_d, to_q, to_d, clr;
  logic is_digit, is_clear, is_enter;
  assign is_digit = key_valid && key_code <= 4'd9;
  assign is_clear = key_valid && key_code == 4'hA;
  assign is_enter = key_valid && key_code == 4'hB;
  // acc*10 + digit in 10 bits; the accumulator only ever holds <=99 when multiplied, so no wrap
  assign acc_w   = {2'b00, acc_q};
  assign acc_nxt = (acc_w << 3) + (acc_w << 1) + {6'd0, key_code};
  // next-state and registered-output logic; key events outrank timeout expiry
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    tmr_d   = tmr_q;
    grd_d   = grd_q;
    cnt_d   = cnt_q;
    pin_d   = pin_q;
    try_d   = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && is_digit) begin
          acc_d   = {4'd0, key_code};
          cnt_d   = 2'd1;
          ovf_d   = 1'b0;
          tmr_d   = '0;
          state_d = COLLECT;
        end else if (enable && is_enter) begin
          err_d = 1'b1;
        end
      end
      COLLECT: begin
        if (!enable) begin
          clr = 1'b1;
        end else if (key_valid) begin
          tmr_d = '0;
          if (is_digit && cnt_q < 2'(NUM_DIGITS)) begin
            acc_d = acc_nxt[7:0];
            ovf_d = ovf_q | (acc_nxt > 10'd255);
            cnt_d = cnt_q + 2'd1;
          end else if (is_clear) begin
            clr = 1'b1;
          end else if (is_enter && ovf_q) begin
            err_d = 1'b1;
            clr   = 1'b1;
          end else if (is_enter) begin
            pin_d   = acc_q;
            try_d   = 1'b1;
            state_d = SEND;
          end
        end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
          to_d = 1'b1;
          clr  = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      SEND: begin
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        grd_d   = '0;
        state_d = GUARD;
      end
      GUARD: begin
        grd_d   = grd_q == GW'(GUARD_CYCLES - 1) ? '0 : grd_q + 1'b1;
        state_d = grd_q == GW'(GUARD_CYCLES - 1) ? IDLE : GUARD;
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      tmr_d   = '0;
      state_d = IDLE;
    end
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      tmr_q   <= '0;
      grd_q   <= '0;
      cnt_q   <= '0;
      pin_q   <= '0;
      try_q   <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      tmr_q   <= tmr_d;
      grd_q   <= grd_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
      try_q   <= try_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end
  assign psswrd_atmpt = pin_q;
  assign try_psswrd   = try_q;
  assign entry_error  = err_q;
  assign timeout      = to_q;
  assign digit_count  = cnt_q;
  assign busy         = state_q != IDLE;
endmodule

// File: tb/tb_keypad_pin_entry.sv
// tb_keypad_pin_entry: directed scenario tests for keypad_pin_entry
module tb_keypad_pin_entry;
  localparam int T = 1000;
  localparam int G = 16;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [7:0] psswrd_atmpt;
  logic try_psswrd, entry_error, timeout, busy;
  logic [1:0] digit_count;
  int n_chk = 0, n_fail = 0;
  keypad_pin_entry #(.NUM_DIGITS(3), .TIMEOUT_CYCLES(T), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .enable(enable), .key_valid(key_valid), .key_code(key_code),
    .psswrd_atmpt(psswrd_atmpt), .try_psswrd(try_psswrd), .entry_error(entry_error),
    .timeout(timeout), .digit_count(digit_count), .busy(busy)
  );
  always #5 clk = ~clk;
  // drive one key for one cycle from a negedge; returns at the negedge after it was sampled
  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 60) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s wait_idle: busy=%b after %0d cycles, required 0", tag, busy, k); end
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    n_chk++;
    if ({psswrd_atmpt, try_psswrd, entry_error, timeout, digit_count, busy} !== 14'd0) begin
      n_fail++; $display("FAIL reset outputs: pin=%h try=%b err=%b to=%b cnt=%0d busy=%b, required all 0", psswrd_atmpt, try_psswrd, entry_error, timeout, digit_count, busy);
    end
  endtask
  task automatic test_submit;
    int nb = 1, nt = 1;
    press(4'd8);
    n_chk++;
    if (digit_count !== 2'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL submit first digit: cnt=%0d busy=%b, required 1/1", digit_count, busy); end
    press(4'd7);
    n_chk++;
    if (digit_count !== 2'd2) begin n_fail++; $display("FAIL submit second digit: cnt=%0d, required 2", digit_count); end
    press(4'hB);
    n_chk++;
    if (try_psswrd !== 1'b1 || psswrd_atmpt !== 8'h57) begin n_fail++; $display("FAIL submit strobe: try=%b pin=%h, required 1/57", try_psswrd, psswrd_atmpt); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (try_psswrd) nt++;
      if (!busy) break;
      nb++;
    end
    n_chk++;
    if (nt !== 1) begin n_fail++; $display("FAIL submit strobe width: %0d cycles, required 1", nt); end
    n_chk++;
    if (nb !== G + 1) begin n_fail++; $display("FAIL submit busy width: %0d cycles, required %0d", nb, G + 1); end
    n_chk++;
    if (psswrd_atmpt !== 8'h57 || digit_count !== 2'd0) begin n_fail++; $display("FAIL submit hold: pin=%h cnt=%0d, required 57/0", psswrd_atmpt, digit_count); end
  endtask
  task automatic test_overflow;
    press(4'd2);
    press(4'd5);
    press(4'd6);
    n_chk++;
    if (digit_count !== 2'd3) begin n_fail++; $display("FAIL overflow cnt: %0d, required 3", digit_count); end
    press(4'hB);
    n_chk++;
    if (entry_error !== 1'b1 || try_psswrd !== 1'b0 || psswrd_atmpt !== 8'h57 || busy !== 1'b0) begin
      n_fail++; $display("FAIL overflow enter: err=%b try=%b pin=%h busy=%b, required 1/0/57/0", entry_error, try_psswrd, psswrd_atmpt, busy);
    end
    @(negedge clk);
    n_chk++;
    if (entry_error !== 1'b0 || try_psswrd !== 1'b0) begin n_fail++; $display("FAIL overflow pulse width: err=%b try=%b, required 0/0", entry_error, try_psswrd); end
  endtask
  task automatic test_clear;
    press(4'hB);
    n_chk++;
    if (entry_error !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL empty enter: err=%b busy=%b, required 1/0", entry_error, busy); end
    press(4'd1);
    press(4'd2);
    press(4'hA);
    n_chk++;
    if (digit_count !== 2'd0 || busy !== 1'b0 || entry_error !== 1'b0) begin n_fail++; $display("FAIL clear: cnt=%0d busy=%b err=%b, required 0/0/0", digit_count, busy, entry_error); end
    press(4'd4);
    press(4'hB);
    n_chk++;
    if (try_psswrd !== 1'b1 || psswrd_atmpt !== 8'h04) begin n_fail++; $display("FAIL clear resubmit: try=%b pin=%h, required 1/04", try_psswrd, psswrd_atmpt); end
    wait_idle("clear");
  endtask
  task automatic test_max_digits;
    press(4'd1);
    press(4'd2);
    press(4'd3);
    press(4'd4);
    n_chk++;
    if (digit_count !== 2'd3) begin n_fail++; $display("FAIL fourth digit cnt: %0d, required 3", digit_count); end
    press(4'hB);
    n_chk++;
    if (try_psswrd !== 1'b1 || psswrd_atmpt !== 8'h7B) begin n_fail++; $display("FAIL max digits: try=%b pin=%h, required 1/7b", try_psswrd, psswrd_atmpt); end
    wait_idle("max_digits");
  endtask
  task automatic test_timeout;
    press(4'd9);
    repeat (T - 1) @(negedge clk);
    n_chk++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL timeout early: to=%b busy=%b, required 0/1", timeout, busy); end
    @(negedge clk);
    n_chk++;
    if (timeout !== 1'b1 || digit_count !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout expiry: to=%b cnt=%0d busy=%b, required 1/0/0", timeout, digit_count, busy); end
    press(4'hB);
    n_chk++;
    if (entry_error !== 1'b1 || timeout !== 1'b0) begin n_fail++; $display("FAIL enter after timeout: err=%b to=%b, required 1/0", entry_error, timeout); end
    press(4'd5);
    repeat (600) @(negedge clk);
    press(4'hC);
    repeat (T - 1) @(negedge clk);
    n_chk++;
    if (timeout !== 1'b0 || digit_count !== 2'd1) begin n_fail++; $display("FAIL ignored key reload: to=%b cnt=%0d, required 0/1", timeout, digit_count); end
    @(negedge clk);
    n_chk++;
    if (timeout !== 1'b1) begin n_fail++; $display("FAIL reloaded expiry: to=%b, required 1", timeout); end
  endtask
  task automatic test_enable_drop;
    press(4'd8);
    press(4'd7);
    enable = 1'b0;
    press(4'hB);
    n_chk++;
    if (try_psswrd !== 1'b0 || entry_error !== 1'b0 || busy !== 1'b0 || digit_count !== 2'd0) begin
      n_fail++; $display("FAIL enable drop: try=%b err=%b busy=%b cnt=%0d, required 0/0/0/0", try_psswrd, entry_error, busy, digit_count);
    end
    press(4'd3);
    n_chk++;
    if (busy !== 1'b0 || digit_count !== 2'd0) begin n_fail++; $display("FAIL disabled key: busy=%b cnt=%0d, required 0/0", busy, digit_count); end
    enable = 1'b1;
  endtask
  task automatic test_guard;
    press(4'd8);
    press(4'd7);
    press(4'hB);
    n_chk++;
    if (try_psswrd !== 1'b1 || psswrd_atmpt !== 8'h57) begin n_fail++; $display("FAIL guard submit: try=%b pin=%h, required 1/57", try_psswrd, psswrd_atmpt); end
    @(negedge clk);
    press(4'd1);
    press(4'd2);
    enable = 1'b0;
    press(4'hB);
    enable = 1'b1;
    n_chk++;
    if (digit_count !== 2'd0 || busy !== 1'b1 || try_psswrd !== 1'b0 || entry_error !== 1'b0) begin
      n_fail++; $display("FAIL guard keys: cnt=%0d busy=%b try=%b err=%b, required 0/1/0/0", digit_count, busy, try_psswrd, entry_error);
    end
    wait_idle("guard");
    n_chk++;
    if (digit_count !== 2'd0) begin n_fail++; $display("FAIL after guard cnt: %0d, required 0", digit_count); end
  endtask
  task automatic test_reset_mid;
    press(4'd8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({psswrd_atmpt, try_psswrd, entry_error, timeout, digit_count, busy} !== 14'd0) begin
      n_fail++; $display("FAIL mid reset: pin=%h try=%b err=%b to=%b cnt=%0d busy=%b, required all 0", psswrd_atmpt, try_psswrd, entry_error, timeout, digit_count, busy);
    end
    press(4'd8);
    press(4'd7);
    press(4'hB);
    n_chk++;
    if (try_psswrd !== 1'b1 || psswrd_atmpt !== 8'h57) begin n_fail++; $display("FAIL post reset submit: try=%b pin=%h, required 1/57", try_psswrd, psswrd_atmpt); end
    wait_idle("reset_mid");
  endtask
  initial begin
    @(negedge clk);
    test_reset;
    test_submit;
    test_overflow;
    test_clear;
    test_max_digits;
    test_timeout;
    test_enable_drop;
    test_guard;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_pin_entry.md
Name: keypad_pin_entry

Overview:
Keypad front-end that feeds the parking access controller. It collects decimal keypresses, converts them to an 8-bit binary PIN, and presents the PIN on psswrd_atmpt with a single-cycle try_psswrd strobe. It drives the controller's password inputs, and its try_psswrd/psswrd_atmpt outputs connect directly to the controller's inputs of the same name. It also handles clear, enter, inactivity timeout and a post-submit guard window.

Parameters:
NUM_DIGITS, 3, maximum decimal digits accepted per entry (1..3).
TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before the entry is discarded (>=2).
GUARD_CYCLES, 16, cycles after a submit during which keys are ignored (>=1).

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
enable  input  1  entry permitted; tied to the controller's car-present condition.
key_valid  input  1  one-cycle strobe; key_code is valid when high.
key_code  input  4  0-9 digit, 4'hA clear, 4'hB enter, 4'hC-4'hF ignored.
psswrd_atmpt  output  8  last submitted PIN, binary.
try_psswrd  output  1  one-cycle submit strobe.
entry_error  output  1  one-cycle pulse on an invalid enter.
timeout  output  1  one-cycle pulse when an entry is discarded for inactivity.
digit_count  output  2  digits held in the current entry.
busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE.
  - psswrd_atmpt=0, try_psswrd=0, entry_error=0, timeout=0, digit_count=0.
  - Accumulator=0, overflow flag=0, timeout and guard counters=0.
  - Reset mid-entry or mid-guard aborts immediately; no strobe is emitted.
- States: IDLE, COLLECT, SEND, GUARD. All outputs are registered.
- IDLE:
  - Enabled digit key: acc=digit, digit_count=1, go to COLLECT.
  - Enter key: entry_error pulse, stay in IDLE.
  - Clear and ignored codes: no effect.
- COLLECT, digit key:
  - If digit_count<NUM_DIGITS: acc = acc*10 + digit, computed in 10 bits. A result >255 sets a sticky overflow flag.
  - If digit_count==NUM_DIGITS: the digit is discarded.
- COLLECT, clear key: acc=0, digit_count=0, overflow=0, go to IDLE.
- COLLECT, enter key:
  - Overflow set: entry_error pulse, state cleared, go to IDLE.
  - Otherwise: psswrd_atmpt<=acc[7:0], try_psswrd=1, go to SEND.
- Latency:
  - Enter sampled at edge N: try_psswrd is high from edge N to edge N+1 only. psswrd_atmpt is already stable when try_psswrd rises.
  - Digit sampled at edge N: digit_count updates at edge N.
- SEND: lasts one cycle. try_psswrd returns to 0, acc/digit_count/overflow clear, go to GUARD.
- GUARD:
  - All keys are ignored.
  - After GUARD_CYCLES cycles, go to IDLE.
  - enable does not shorten the guard window.
- psswrd_atmpt holds its value until the next submit or reset.
- Timeout:
  - The counter runs only in COLLECT and reloads to 0 on any key_valid, including ignored codes.
  - On reaching TIMEOUT_CYCLES: timeout pulse, state cleared, go to IDLE.
- enable low in IDLE or COLLECT: the entry is discarded (no pulse), state goes to IDLE, keys are ignored.
- Priority when events coincide in one cycle: rst > enable low > key event > timeout expiry. A key arriving on the expiry cycle wins and reloads the counter.
- Pulse exclusivity: at most one of try_psswrd, entry_error, timeout is high in any cycle.

Test Plan:
1. enable=1; keys 8,7,B → cycle after B: psswrd_atmpt=8'h57 (87), try_psswrd high exactly 1 cycle; busy stays high for GUARD_CYCLES+1 cycles, then IDLE.
2. keys 2,5,6,B → overflow (256); entry_error pulses 1 cycle; try_psswrd never asserts; psswrd_atmpt unchanged.
3. B with no digits → entry_error 1 cycle; keys 1,2,A,4,B → psswrd_atmpt=8'h04, one try_psswrd strobe.
4. key 9, then no key for TIMEOUT_CYCLES → timeout pulses 1 cycle, digit_count=0; a following B gives entry_error.
5. keys 8,7, enable dropped in the same cycle as B → no try_psswrd, state IDLE; digits pressed during GUARD after a valid submit are ignored and digit_count stays 0.
6. rst asserted one cycle after digit 8 → all outputs 0 next cycle; a subsequent 8,7,B submits 8'h57 normally.
